fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the IF stage: owns the PC register, chooses the next PC and drives the instruction-memory request.
//  Arbitrates between four next-PC sources: sequential PC+2, branch redirect from ID, stall hold and halt freeze.
//  Handles a multi-cycle imem handshake, including redirects that arrive while a miss is outstanding.
//  Sits between the hazard unit, the branch resolver in ID and the instruction memory/cache.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
//  PC_STEP   16'h0002  sequential increment (one 16-bit instruction)
// PORTS
//  clk            in   1   system clock; all state updates on the rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  stall          in   1   hazard unit: hold PC and the IF/ID contents
//  halt           in   1   HLT decoded on the instruction currently in IF
//  br_taken       in   1   ID stage: branch/jump resolved taken
//  br_target      in   16  ID stage: redirect address
//  pc_id          in   16  PC+2 value currently held in IF/ID
//  imem_ready     in   1   imem: data valid for imem_addr this cycle
//  imem_req       out  1   imem: fetch request
//  imem_addr      out  16  imem: fetch address (= pc)
//  pc             out  16  current fetch PC (registered)
//  pc_inc         out  16  PC+2 forwarded to IF/ID (= pc_id when stall)
//  if_valid       out  1   fetched instruction is valid for IF/ID capture
//  flush_if       out  1   squash the wrong-path instruction in IF
//  halted         out  1   processor halted (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, state=FETCH, pend_vld=0, halted=0.
//   - imem_req, if_valid and flush_if are combinational and read 0 while rst_n=0.
//  States: FETCH, MISS, HALTED.
//   - imem_req=1 in FETCH and MISS; imem_req=0 in HALTED.
//   - imem_addr=pc at all times.
//  FETCH with imem_ready=1: next-PC priority is br_taken > halt > stall > sequential.
//   - br_taken: pc<=br_target, flush_if=1, if_valid=0.
//   - halt (no br_taken): pc holds, if_valid=1 so HLT enters ID, next state HALTED.
//   - stall (no br_taken/halt): pc holds, if_valid=1, IF/ID holds.
//   - none of the above: pc<=pc+PC_STEP, if_valid=1.
//  FETCH with imem_ready=0: pc holds, if_valid=0, next state MISS.
//   - br_taken in this cycle: pend_vld<=1, pend_tgt<=br_target, flush_if=1.
//  MISS:
//   - imem_req stays 1 with the address unchanged; if_valid=0 until imem_ready.
//   - br_taken during MISS: latch pend_tgt; a later br_taken overwrites it; flush_if=1.
//   - imem_ready with pend_vld=1: data discarded (if_valid=0), pc<=pend_tgt, pend_vld<=0, next state FETCH.
//   - imem_ready with pend_vld=0: behaves as FETCH with imem_ready=1 (same priority rules), next state FETCH or HALTED.
//  HALTED:
//   - pc frozen, if_valid=0, halted=1.
//   - br_taken, stall and halt are ignored; only rst_n exits.
//  pc_inc = stall ? pc_id : pc+PC_STEP, combinational in every state.
//  Arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000 with no flag. br_target[0] is ignored (forced to 0).
//  Single-cycle latency: imem_ready in cycle N -> new pc visible in cycle N+1.
//  Reset mid-MISS: request dropped immediately, pending redirect cleared. Memory must tolerate the abandoned request.
//  halt and br_taken in the same cycle: redirect wins and halt is ignored (HLT was on the wrong path).
// TESTING
//  1. Reset release, imem_ready=1 for 4 cycles -> pc = 0000,0002,0004,0006; if_valid=1 throughout.
//  2. pc=0010, stall=1 for 2 cycles -> pc stays 0010; pc_inc=pc_id; resume -> 0012.
//  3. pc=0020, br_taken=1, br_target=0100 -> flush_if=1 same cycle; pc=0100 next cycle.
//  4. imem_ready=0 at pc=0030 for 3 cycles, br_taken=1 (tgt 0200) in cycle 2
//     -> on ready: if_valid=0, pc=0200.
//  5. halt=1 at pc=0040 -> if_valid=1 that cycle; then halted=1, imem_req=0, pc=0040 forever.
//     halt+br_taken together -> redirect wins.
//  6. pc=FFFE sequential -> pc=0000. rst_n pulsed low mid-MISS -> pc=RESET_PC, imem_req=0 asynchronously.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch channel between the IF-stage sequencer and imem/cache.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, picks the next PC (redirect/halt/stall/sequential)
// and runs the multi-cycle imem handshake, parking redirects that arrive during a miss.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0002
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          br_taken_i,
    input  logic [15:0]   br_target_i,
    input  logic [15:0]   pc_id_i,
    fetch_ctrl_if.master  imem,
    output logic [15:0]   pc_o,
    output logic [15:0]   pc_inc_o,
    output logic          if_valid_o,
    output logic          flush_if_o,
    output logic          halted_o
);

    typedef enum logic [1:0] {StFetch, StMiss, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] pend_tgt_q, pend_tgt_d;

    logic [15:0] br_tgt;
    logic [15:0] pc_seq;
    logic        req;
    logic        if_valid;
    logic        flush;

    assign br_tgt = {br_target_i[15:1], 1'b0};
    assign pc_seq = pc_q + PC_STEP;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        req        = 1'b0;
        if_valid   = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            StFetch, StMiss: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    state_d = StFetch;
                    if (state_q == StMiss && pend_vld_q) begin
                        // Data is from the wrong path; a redirect in this very cycle is newer.
                        pend_vld_d = 1'b0;
                        pc_d       = pend_tgt_q;
                        if (br_taken_i) begin
                            pc_d  = br_tgt;
                            flush = 1'b1;
                        end
                    end else if (br_taken_i) begin
                        pc_d  = br_tgt;
                        flush = 1'b1;
                    end else if (halt_i) begin
                        if_valid = 1'b1;
                        state_d  = StHalted;
                    end else if (stall_i) begin
                        if_valid = 1'b1;
                    end else begin
                        pc_d     = pc_seq;
                        if_valid = 1'b1;
                    end
                end else begin
                    state_d = StMiss;
                    if (br_taken_i) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = br_tgt;
                        flush      = 1'b1;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= RESET_PC;
            halted_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            halted_o   <= (state_d == StHalted);
        end
    end

    // Handshake outputs are forced low while reset is asserted, abandoning any request.
    assign imem.imem_req  = req & rst_n;
    assign imem.imem_addr = pc_q;
    assign if_valid_o     = if_valid & rst_n;
    assign flush_if_o     = flush & rst_n;
    assign pc_o           = pc_q;
    assign pc_inc_o       = stall_i ? pc_id_i : pc_seq;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: the driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc_id;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        if_valid;
    logic        flush_if;
    logic        halted;

    fetch_ctrl_if imem ();

    fetch_ctrl #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'h0002)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall),
        .halt_i      (halt),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .pc_id_i     (pc_id),
        .imem        (imem.master),
        .pc_o        (pc),
        .pc_inc_o    (pc_inc),
        .if_valid_o  (if_valid),
        .flush_if_o  (flush_if),
        .halted_o    (halted)
    );

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] pc_inc;
        logic        vld;
        logic        flush;
        logic        req;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "pc",       pc,                     e.pc);
            cmp(e.name, "pc_inc",   pc_inc,                 e.pc_inc);
            cmp(e.name, "if_valid", {15'd0, if_valid},      {15'd0, e.vld});
            cmp(e.name, "flush_if", {15'd0, flush_if},      {15'd0, e.flush});
            cmp(e.name, "imem_req", {15'd0, imem.imem_req}, {15'd0, e.req});
            cmp(e.name, "halted",   {15'd0, halted},        {15'd0, e.halted});
            cmp(e.name, "imem_addr", imem.imem_addr,        e.pc);
        end
    end

    task automatic step(input string name, input logic rst, input logic st, input logic hl,
                        input logic br, input logic [15:0] tgt, input logic [15:0] pid,
                        input logic rdy, input logic [15:0] e_pc, input logic [15:0] e_inc,
                        input logic e_vld, input logic e_fl, input logic e_req,
                        input logic e_hlt);
        exp_t e;
        rst_n           = rst;
        stall           = st;
        halt            = hl;
        br_taken        = br;
        br_target       = tgt;
        pc_id           = pid;
        imem.imem_ready = rdy;
        e.name   = name;
        e.pc     = e_pc;
        e.pc_inc = e_inc;
        e.vld    = e_vld;
        e.flush  = e_fl;
        e.req    = e_req;
        e.halted = e_hlt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input string name, input logic [15:0] p);
        step(name, 1, 0, 0, 0, 16'h0, 16'h0, 1, p, p + 16'h2, 1, 0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; halt = 0; br_taken = 0; br_target = 0; pc_id = 0;
        imem.imem_ready = 1'b1;
        @(posedge clk);
        #1;
        //    name        rst st hl br tgt       pc_id     rdy  pc        inc       vld fl req hlt
        step("reset",     0, 0, 0, 0, 16'h0,    16'h0,    1,   16'h0000, 16'h0002, 0, 0, 0, 0);
        seq("seq0", 16'h0000);
        seq("seq1", 16'h0002);
        seq("seq2", 16'h0004);
        seq("seq3", 16'h0006);
        for (int i = 0; i < 4; i++) seq("seq_run", 16'h0008 + 16'(2 * i));
        step("stall1",    1, 1, 0, 0, 16'h0,    16'h1234, 1,   16'h0010, 16'h1234, 1, 0, 1, 0);
        step("stall2",    1, 1, 0, 0, 16'h0,    16'h1234, 1,   16'h0010, 16'h1234, 1, 0, 1, 0);
        seq("resume", 16'h0010);
        step("br_odd",    1, 0, 0, 1, 16'h0021, 16'h0,    1,   16'h0012, 16'h0014, 0, 1, 1, 0);
        step("br100",     1, 0, 0, 1, 16'h0100, 16'h0,    1,   16'h0020, 16'h0022, 0, 1, 1, 0);
        step("br30",      1, 0, 0, 1, 16'h0030, 16'h0,    1,   16'h0100, 16'h0102, 0, 1, 1, 0);
        step("miss_c1",   1, 0, 0, 0, 16'h0,    16'h0,    0,   16'h0030, 16'h0032, 0, 0, 1, 0);
        step("miss_c2br", 1, 0, 0, 1, 16'h0200, 16'h0,    0,   16'h0030, 16'h0032, 0, 1, 1, 0);
        step("miss_c3",   1, 0, 0, 0, 16'h0,    16'h0,    0,   16'h0030, 16'h0032, 0, 0, 1, 0);
        step("miss_rdy",  1, 0, 0, 0, 16'h0,    16'h0,    1,   16'h0030, 16'h0032, 0, 0, 1, 0);
        seq("redirected", 16'h0200);
        step("halt_br",   1, 0, 1, 1, 16'h0040, 16'h0,    1,   16'h0202, 16'h0204, 0, 1, 1, 0);
        step("halt",      1, 0, 1, 0, 16'h0,    16'h0,    1,   16'h0040, 16'h0042, 1, 0, 1, 0);
        step("halted1",   1, 1, 1, 1, 16'h0500, 16'h1111, 1,   16'h0040, 16'h1111, 0, 0, 0, 1);
        step("halted2",   1, 0, 0, 0, 16'h0,    16'h0,    1,   16'h0040, 16'h0042, 0, 0, 0, 1);
        step("reset2",    0, 0, 0, 0, 16'h0,    16'h0,    1,   16'h0000, 16'h0002, 0, 0, 0, 0);
        step("br_fffe",   1, 0, 0, 1, 16'hFFFF, 16'h0,    1,   16'h0000, 16'h0002, 0, 1, 1, 0);
        seq("wrap", 16'hFFFE);
        seq("wrapped", 16'h0000);
        step("mr_miss",   1, 0, 0, 1, 16'h0300, 16'h0,    0,   16'h0002, 16'h0004, 0, 1, 1, 0);
        step("mr_wait",   1, 0, 0, 0, 16'h0,    16'h0,    0,   16'h0002, 16'h0004, 0, 0, 1, 0);
        // Asserted mid-cycle: the next negedge sample precedes any rising edge.
        step("mr_rst",    0, 0, 0, 0, 16'h0,    16'h0,    0,   16'h0000, 16'h0002, 0, 0, 0, 0);
        seq("post_rst", 16'h0000);
        step("plain_miss",1, 0, 0, 0, 16'h0,    16'h0,    0,   16'h0002, 16'h0004, 0, 0, 1, 0);
        step("plain_rdy", 1, 0, 0, 0, 16'h0,    16'h0,    1,   16'h0002, 16'h0004, 1, 0, 1, 0);
        seq("final", 16'h0004);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
